// File: rtl/inv_sqrt_pkg.sv
// Constants and types shared by the float<->fixed converters around the
// inverse-sqrt core.
package inv_sqrt_pkg;

  localparam int FLOAT_BIAS = 127;
  localparam int EXP_W      = 8;
  localparam int MANT_W     = 23;
  localparam int FLOAT_W    = 1 + EXP_W + MANT_W;
  localparam int FXP_W      = 32;
  localparam int FXP_FRAC   = 16;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    PACK
  } convState_e;

  // Sign is always zero on this path: the fixed-point side is unsigned.
  function automatic logic [FLOAT_W-1:0] packFloat(input logic [EXP_W-1:0]  expField,
                                                   input logic [MANT_W-1:0] mantField);
    return {1'b0, expField, mantField};
  endfunction

endpackage

// File: rtl/fxp_normalizer.sv
// Iterative normaliser: shifts the operand left one bit per clock until the
// MSB is set, counting the shifts as the leading-zero count.
module fxp_normalizer
  import inv_sqrt_pkg::*;
#(
  parameter int WIDTH = FXP_W,
  parameter int LZ_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sr,
  output logic [LZ_W-1:0]  lz,
  output logic             done,
  output logic             zero
);

  logic [WIDTH-1:0] sr_q;
  logic [LZ_W-1:0]  lz_q;

  assign done = sr_q[WIDTH-1];
  assign zero = (sr_q == '0);

  // Once normalised (or found to be zero) the register freezes, so the
  // result stays put for the packing cycle and while the converter idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
      lz_q <= '0;
    end else if (load) begin
      sr_q <= d;
      lz_q <= '0;
    end else if (!done && !zero) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
      lz_q <= lz_q + LZ_W'(1);
    end
  end

  assign sr = sr_q;
  assign lz = lz_q;

endmodule

// File: rtl/fxp_to_float.sv
// Unsigned Q16.16 to IEEE-754 single converter: load, normalise iteratively,
// then pack exponent and truncated mantissa into a held output register.
module fxp_to_float
  import inv_sqrt_pkg::*;
#(
  parameter int WIDTH     = FXP_W,
  parameter int FRAC_BITS = FXP_FRAC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   fxp_in_i,
  output logic [FLOAT_W-1:0] float_out_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int LZ_W       = $clog2(WIDTH);
  localparam int EXP_OFFSET = FLOAT_BIAS + WIDTH - 1 - FRAC_BITS;

  convState_e         state_q, state_d;
  logic [FLOAT_W-1:0] floatOut_q, floatOut_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               load;
  logic [WIDTH-1:0]   sr;
  logic [LZ_W-1:0]    lz;
  logic               done;
  logic               zero;
  logic [EXP_W-1:0]   expVal;
  logic               unusedBits;

  fxp_normalizer #(
    .WIDTH(WIDTH),
    .LZ_W (LZ_W)
  ) uNormalizer (
    .clk (clk),
    .rst (rst),
    .load(load),
    .d   (fxp_in_i),
    .sr  (sr),
    .lz  (lz),
    .done(done),
    .zero(zero)
  );

  // Each shift halves the weight of the MSB, so the exponent drops by lz.
  assign expVal     = EXP_W'(EXP_OFFSET) - EXP_W'(lz);
  assign unusedBits = ^{sr[WIDTH-1], sr[WIDTH-2-MANT_W:0]};

  always_comb begin
    state_d    = state_q;
    floatOut_d = floatOut_q;
    ready_d    = 1'b0;
    busy_d     = busy_q;
    load       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = NORM;
        end
      end
      NORM: begin
        if (zero || done) begin
          state_d = PACK;
        end
      end
      PACK: begin
        floatOut_d = zero ? '0 : packFloat(expVal, sr[WIDTH-2 -: MANT_W]);
        ready_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      floatOut_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      floatOut_q <= floatOut_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign float_out_o = floatOut_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fxp_to_float.sv
// Self-checking bench for fxp_to_float: directed table, reference-model
// random vectors, and hand-written handshake/reset sequences.
module tb_fxp_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] fxpIn;
  logic [31:0] floatOut;
  logic        ready;
  logic        busy;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [31:0] operand;
    logic [31:0] expected;
    int          latency;
    string       name;
  } vector_t;

  vector_t vectors[6];

  fxp_to_float dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .fxp_in_i   (fxpIn),
    .float_out_o(floatOut),
    .ready_o    (ready),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Value semantics: operand/2^16 = 2^p * (1 + m/2^23), mantissa truncated.
  function automatic void refModel(input logic [31:0] x, output logic [31:0] f,
                                   output int latency);
    longint     v;
    longint     rem;
    longint     mant;
    int         p;
    logic [7:0] e;
    v = longint'(x);
    if (v == 0) begin
      f       = 32'h0;
      latency = 2;
      return;
    end
    p = 31;
    while ((longint'(1) << p) > v) p--;
    rem  = v - (longint'(1) << p);
    mant = (p >= 23) ? (rem >> (p - 23)) : (rem << (23 - p));
    e    = 8'(127 + p - 16);
    f    = {1'b0, e, mant[22:0]};
    latency = 33 - p;
  endfunction

  // Called just after a clock edge; start is sampled on the next edge.
  task automatic applyStimulus(input logic [31:0] operand, input logic [31:0] expected,
                               input int latency, input string name);
    logic [31:0] heldValue;
    int          cycles     = 0;
    int          busyCycles = 0;
    bit          seen       = 1'b0;
    bit          holdOk     = 1'b1;
    heldValue = floatOut;
    start = 1'b1;
    fxpIn = operand;
    @(posedge clk); #1;
    start = 1'b0;
    fxpIn = $urandom;
    if (busy) busyCycles++;
    while (!seen && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (ready) seen = 1'b1;
      else begin
        if (busy) busyCycles++;
        if (floatOut !== heldValue) holdOk = 1'b0;
      end
    end
    checkOutput({name, " latency"}, seen ? cycles : -1, latency);
    checkOutput({name, " value"}, floatOut, expected);
    checkOutput({name, " busy cycles"}, busyCycles, latency);
    checkOutput({name, " busy at ready"}, {31'b0, busy}, 32'h0);
    checkOutput({name, " hold before ready"}, {31'b0, holdOk}, 32'h1);
    @(posedge clk); #1;
    checkOutput({name, " ready width"}, {31'b0, ready}, 32'h0);
    checkOutput({name, " value held"}, floatOut, expected);
  endtask

  initial begin
    logic [31:0] operand;
    logic [31:0] expected;
    int          latency;
    int          pulses;
    int          readyEdge;
    int          busySeen;

    vectors[0] = '{32'h0001_0000, 32'h3F80_0000, 17, "one"};
    vectors[1] = '{32'h8000_0000, 32'h4700_0000,  2, "msb"};
    vectors[2] = '{32'h0000_0001, 32'h3780_0000, 33, "lsb"};
    vectors[3] = '{32'h0001_8000, 32'h3FC0_0000, 17, "one_half"};
    vectors[4] = '{32'hFFFF_FFFF, 32'h477F_FFFF,  2, "all_ones"};
    vectors[5] = '{32'h0000_0000, 32'h0000_0000,  2, "zero"};

    rst   = 1'b1;
    start = 1'b0;
    fxpIn = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset float_out", floatOut, 32'h0);
    checkOutput("reset ready", {31'b0, ready}, 32'h0);
    checkOutput("reset busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vectors[i].operand, vectors[i].expected, vectors[i].latency,
                    vectors[i].name);
    end

    for (int i = 0; i < 120; i++) begin
      operand = (i % 17 == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      refModel(operand, expected, latency);
      applyStimulus(operand, expected, latency, $sformatf("random%0d %h", i, operand));
    end

    // Extra starts while busy and on the packing edge must be dropped.
    start = 1'b1;
    fxpIn = 32'h0001_0000;
    @(posedge clk); #1;
    pulses    = 0;
    readyEdge = -1;
    for (int k = 1; k <= 17; k++) begin
      start = (k == 3 || k == 17);
      fxpIn = 32'h0002_0000;
      @(posedge clk); #1;
      if (ready) begin
        pulses++;
        readyEdge = k;
      end
    end
    start = 1'b0;
    checkOutput("reject pulses", pulses, 1);
    checkOutput("reject ready edge", readyEdge, 17);
    checkOutput("reject value", floatOut, 32'h3F80_0000);
    applyStimulus(32'h0002_0000, 32'h4000_0000, 16, "accept after ready");

    // Reset mid-conversion aborts without a result.
    start = 1'b1;
    fxpIn = 32'h0001_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort busy", {31'b0, busy}, 32'h0);
    checkOutput("abort float_out", floatOut, 32'h0);
    checkOutput("abort ready", {31'b0, ready}, 32'h0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    checkOutput("abort no ready", pulses, 0);

    // Reset takes priority over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    fxpIn = 32'h0001_0000;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    pulses   = 0;
    busySeen = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) busySeen++;
      if (ready) pulses++;
      @(posedge clk); #1;
    end
    checkOutput("rst+start busy", busySeen, 0);
    checkOutput("rst+start ready", pulses, 0);
    checkOutput("rst+start float_out", floatOut, 32'h0);

    applyStimulus(32'h0003_0000, 32'h4040_0000, 16, "after reset");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
